// File: rtl/dpsk_tx_scheduler.sv
// dpsk_tx_scheduler: frame sequencer (preamble, MSB-first data, tail) feeding the DPSK modulator
module dpsk_tx_scheduler #(
    parameter int SPS       = 4,
    parameter int PRE_BITS  = 8,
    parameter int TAIL_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       serial_data,
    output logic       mod_rst,
    output logic       sym_strobe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int SW = $clog2(SPS);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    bytes_left_q, bytes_left_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          mod_rst_q, mod_rst_d;
    logic          sym_end, last_pre, last_bit, fetch;

    assign sym_end     = sym_cnt_q == SW'(SPS - 1);
    assign last_pre    = state_q == PREAMBLE && idx_q == 8'(PRE_BITS - 1);
    assign last_bit    = state_q == DATA && bit_idx_q == 3'd7;
    assign fetch       = sym_end && (last_pre || (last_bit && bytes_left_q > 8'd1));
    assign byte_ready  = fetch;
    assign underrun    = fetch && !byte_valid;
    assign done        = state_q == TAIL && sym_end && idx_q == 8'(TAIL_BITS - 1);
    assign sym_strobe  = state_q != IDLE && sym_cnt_q == '0;
    assign serial_data = serial_q;
    assign busy        = busy_q;
    assign mod_rst     = mod_rst_q;

    // state and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            idx_q        <= '0;
            bit_idx_q    <= '0;
            bytes_left_q <= '0;
            shreg_q      <= '0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
            mod_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            idx_q        <= idx_d;
            bit_idx_q    <= bit_idx_d;
            bytes_left_q <= bytes_left_d;
            shreg_q      <= shreg_d;
            serial_q     <= serial_d;
            busy_q       <= busy_d;
            mod_rst_q    <= mod_rst_d;
        end
    end

    // next-state: idx_q counts preamble symbols, then tail symbols
    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = (state_q == IDLE || sym_end) ? '0 : sym_cnt_q + 1'b1;
        idx_d        = idx_q;
        bit_idx_d    = bit_idx_q;
        bytes_left_d = bytes_left_q;
        shreg_d      = shreg_q;
        serial_d     = serial_q;
        busy_d       = busy_q;
        mod_rst_d    = mod_rst_q;
        case (state_q)
            IDLE: if (start && frame_len != 8'd0) begin
                state_d      = PREAMBLE;
                idx_d        = '0;
                bytes_left_d = frame_len;
                serial_d     = 1'b1;
                busy_d       = 1'b1;
                mod_rst_d    = 1'b0;
            end
            PREAMBLE: if (sym_end && !last_pre) begin
                idx_d    = idx_q + 8'd1;
                serial_d = idx_q[0];
            end
            DATA: if (sym_end) begin
                if (!last_bit) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    shreg_d   = shreg_q << 1;
                    serial_d  = shreg_q[6];
                end else begin
                    bytes_left_d = bytes_left_q - 8'd1;
                    if (bytes_left_q == 8'd1) begin
                        state_d  = TAIL;
                        idx_d    = '0;
                        serial_d = 1'b1;
                    end
                end
            end
            TAIL: if (sym_end) begin
                if (done) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    serial_d  = 1'b1;
                    busy_d    = 1'b0;
                    mod_rst_d = 1'b1;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
        endcase
        if (fetch) begin
            if (byte_valid) begin
                state_d   = DATA;
                shreg_d   = byte_data;
                bit_idx_d = '0;
                serial_d  = byte_data[7];
            end else begin
                state_d  = TAIL;
                idx_d    = '0;
                serial_d = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dpsk_tx_scheduler.sv
// tb_dpsk_tx_scheduler: randomized frame scenarios checked against a symbol-list model
module tb_dpsk_tx_scheduler;
    localparam int SPS = 4, PRE = 8, TAIL = 2;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0] frame_len = 8'd0, byte_data = 8'd0;
    logic       byte_ready, serial_data, mod_rst, sym_strobe, busy, done, underrun;
    int         vectors = 0, errors = 0;
    logic [7:0] bytes_q[$];

    dpsk_tx_scheduler #(.SPS(SPS), .PRE_BITS(PRE), .TAIL_BITS(TAIL)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .serial_data(serial_data), .mod_rst(mod_rst), .sym_strobe(sym_strobe),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {busy, mod_rst, serial_data, sym_strobe, byte_ready, underrun, done};
    endfunction

    // Runs one frame from a start command; bad_fetch = index of fetch with byte_valid low (-1 none);
    // abort_at != 0 asserts rst during that frame cycle. Frame cycle k is the k-th cycle after the start edge.
    task automatic run_frame(input int len, input int bad_fetch, input bit mid_start, input int abort_at,
                             output int nbusy, output int nrdy, output int nstb);
        bit sym[$];
        int fetch_cyc[$];
        int ur_cyc = -1, total, fj;
        logic [6:0] exp_v;
        nbusy = 0; nrdy = 0; nstb = 0;
        while (bytes_q.size() < len) bytes_q.push_back(8'($urandom));
        for (int i = 0; i < PRE; i++) sym.push_back(i % 2 == 0);
        for (int j = 0; j < len; j++) begin
            fetch_cyc.push_back(SPS * sym.size());
            if (j == bad_fetch) begin
                ur_cyc = SPS * sym.size();
                break;
            end
            for (int b = 7; b >= 0; b--) sym.push_back(bytes_q[j][b]);
        end
        for (int i = 0; i < TAIL; i++) sym.push_back(1'b1);
        total = SPS * sym.size();
        @(negedge clk);
        start = 1'b1; frame_len = 8'(len); byte_valid = 1'($urandom); byte_data = 8'($urandom);
        #1;
        vectors++;
        if (outs() !== 7'b0110000) begin
            errors++;
            $display("FAIL idle_before_start: got %b want 0110000", outs());
        end
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            start = (mid_start && k < total) ? 1'($urandom) : 1'b0;
            frame_len = 8'($urandom);
            fj = -1;
            foreach (fetch_cyc[j]) if (fetch_cyc[j] == k) fj = j;
            byte_valid = (fj >= 0) ? (fj != bad_fetch) : 1'($urandom);
            byte_data = (fj >= 0) ? bytes_q[fj] : 8'($urandom);
            #1;
            exp_v = {1'b1, 1'b0, sym[(k-1)/SPS], ((k-1) % SPS == 0), (fj >= 0), (k == ur_cyc), (k == total)};
            vectors++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL frame_cycle_%0d {busy,mod_rst,serial,strobe,ready,underrun,done}: got %b want %b",
                         k, outs(), exp_v);
            end
            nbusy += int'(busy); nrdy += int'(byte_ready); nstb += int'(sym_strobe);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                vectors++;
                if ({busy, mod_rst, serial_data, done} !== 4'b0110) begin
                    errors++;
                    $display("FAIL abort {busy,mod_rst,serial,done}: got %b want 0110",
                             {busy, mod_rst, serial_data, done});
                end
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        vectors++;
        if (nbusy != total || nrdy != fetch_cyc.size() || nstb != total / SPS) begin
            errors++;
            $display("FAIL frame_totals busy/ready/strobe: got %0d/%0d/%0d want %0d/%0d/%0d",
                     nbusy, nrdy, nstb, total, fetch_cyc.size(), total / SPS);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (outs() !== 7'b0110000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0110000", outs());
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs() !== 7'b0110000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 0110000", outs());
        end
    endtask

    task automatic test_single_a5();
        int nb, nr, ns;
        bytes_q = {8'hA5};
        run_frame(1, -1, 1'b0, 0, nb, nr, ns);
        vectors++;
        if (nb != 72 || nr != 1 || ns != 18) begin
            errors++;
            $display("FAIL single_a5 busy/ready/strobe: got %0d/%0d/%0d want 72/1/18", nb, nr, ns);
        end
    endtask

    task automatic test_two_bytes();
        int nb, nr, ns;
        bytes_q = {8'h00, 8'hFF};
        run_frame(2, -1, 1'b0, 0, nb, nr, ns);
        vectors++;
        if (nb != 104 || nr != 2) begin
            errors++;
            $display("FAIL two_bytes busy/ready: got %0d/%0d want 104/2", nb, nr);
        end
    endtask

    task automatic test_underrun();
        int nb, nr, ns;
        bytes_q = {8'($urandom), 8'($urandom)};
        run_frame(2, 1, 1'b0, 0, nb, nr, ns);
        vectors++;
        if (nb != 72 || nr != 2) begin
            errors++;
            $display("FAIL underrun busy/ready: got %0d/%0d want 72/2", nb, nr);
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1'b1; frame_len = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            byte_valid = 1'($urandom);
            #1;
            vectors++;
            if (outs() !== 7'b0110000) begin
                errors++;
                $display("FAIL zero_len_idle: got %b want 0110000", outs());
            end
        end
    endtask

    task automatic test_mid_start();
        int nb, nr, ns;
        bytes_q.delete();
        run_frame(3, -1, 1'b1, 0, nb, nr, ns);
    endtask

    task automatic test_rst_mid_data();
        int nb, nr, ns;
        bytes_q.delete();
        run_frame(2, -1, 1'b0, 45, nb, nr, ns);
        bytes_q.delete();
        run_frame(1, -1, 1'b0, 0, nb, nr, ns);
    endtask

    task automatic test_back_to_back();
        int nb, nr, ns, len, bad;
        for (int f = 0; f < 6; f++) begin
            bytes_q.delete();
            len = $urandom_range(1, 4);
            bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            run_frame(len, bad, 1'($urandom), 0, nb, nr, ns);
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_two_bytes();
        test_underrun();
        test_zero_len();
        test_mid_start();
        test_rst_mid_data();
        test_back_to_back();
        @(negedge clk);
        vectors++;
        if (outs() !== 7'b0110000) begin
            errors++;
            $display("FAIL final_idle: got %b want 0110000", outs());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dpsk_tx_scheduler.md
Name: dpsk_tx_scheduler

Overview:
- Frame-level sequencer in front of the DPSK modulator top (`dpsk_modulator`).
- Accepts a start command and frame length, then pulls bytes over a valid/ready handshake.
- Serializes each frame as preamble, then data MSB-first, then tail, at a fixed clock-cycles-per-symbol rate.
- Drives the modulator's serial_data and holds the modulator in reset between frames.

Parameters:
- SPS, 4: clock cycles per symbol; legal values are 2 and above.
- PRE_BITS, 8: preamble length in symbols; pattern alternates 1,0,1,0,... starting with 1.
- TAIL_BITS, 2: tail length in symbols, all 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  frame start request, sampled in IDLE only
- frame_len  in  8  number of data bytes in the frame; latched on start
- byte_data  in  8  data byte
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  scheduler takes byte_data this cycle
- serial_data  out  1  bit to the modulator serial_data input
- mod_rst  out  1  reset to the modulator; high whenever the scheduler is idle
- sym_strobe  out  1  high on the first cycle of every symbol
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the frame ends
- underrun  out  1  one-cycle pulse when a byte was needed but byte_valid was low

Behaviour:
- Reset is rst: asynchronous, active-high. The clock is clk.
- Reset values: state=IDLE, serial_data=1, mod_rst=1, busy=0, done=0, underrun=0, sym_strobe=0, byte_ready=0, all counters 0.
- Asserting rst mid-frame aborts the frame immediately. No done pulse is generated.
- States: IDLE, PREAMBLE, DATA, TAIL.
- Symbol timer sym_cnt is $clog2(SPS) bits wide.
  - It counts 0..SPS-1 in every non-IDLE state and wraps to 0.
  - sym_end = (sym_cnt==SPS-1).
  - sym_strobe = non-IDLE && sym_cnt==0.
- IDLE:
  - Transition: on start=1 with frame_len!=0, latch frame_len into bytes_left, sym_cnt=0, pre_idx=0, go to PREAMBLE.
  - start with frame_len=0 is ignored.
  - start in any non-IDLE state is ignored.
- Latency: from the first clk edge after the start-sampling edge, busy=1, mod_rst=0, and serial_data = preamble bit 0 (=1).
- serial_data, busy and mod_rst are registered. serial_data changes only on symbol boundaries.
- PREAMBLE: serial_data = ~pre_idx[0]. pre_idx increments on sym_end. The last preamble symbol ends the state.
- byte_ready (combinational from registered state) is high only on a fetch cycle:
  - the sym_end of the last preamble symbol, or
  - the sym_end of data bit 7 when bytes_left>1.
- Fetch cycle with byte_valid=1:
  - shift register is loaded with byte_data; bit_idx=0.
  - the next symbol carries byte_data[7]; state is DATA.
  - bytes_left decrements when bit 7 of a byte completes.
- Fetch cycle with byte_valid=0:
  - underrun pulses in that same cycle; go to TAIL.
  - The remaining bytes are dropped, and the frame still finishes normally through TAIL.
- byte_valid outside fetch cycles has no effect; nothing is consumed.
- DATA: serial_data = current shift-register MSB. On sym_end:
  - bits 0..6: shift left by 1.
  - bit 7 with bytes_left==1: go to TAIL.
- TAIL:
  - serial_data=1 for TAIL_BITS symbols.
  - On sym_end of the last tail symbol: done=1 for one cycle, state goes to IDLE.
  - From the next edge: busy=0, mod_rst=1, serial_data=1.
- Frame duration without underrun is SPS*(PRE_BITS + 8*frame_len + TAIL_BITS) cycles of busy=1.
- A new start can be accepted on the cycle after done.

Test Plan:
- frame_len=1, byte 0xA5 held valid, default parameters.
  - Symbols: 10101010, 10100101, 11, each held 4 cycles.
  - busy high for 72 cycles; byte_ready high for exactly 1 cycle (cycle 32 of the frame).
  - done pulses on the 72nd cycle; sym_strobe asserted 18 times.
- frame_len=2, bytes 0x00 then 0xFF, valid always high.
  - byte_ready pulses twice, 32 cycles apart.
  - Data symbols: eight 0s, then eight 1s.
  - busy = 104 cycles.
- frame_len=2, byte_valid deasserted before the second fetch.
  - underrun pulses in the fetch cycle, followed by 2 tail symbols of 1 and done.
  - busy = 72 cycles; the second byte is not consumed.
- Ignored starts:
  - start with frame_len=0: no busy, no byte_ready.
  - start pulsed mid-frame: no effect, frame length unchanged.
- rst asserted mid-DATA:
  - Immediately serial_data=1, mod_rst=1, busy=0, no done.
  - A following start with frame_len=1 runs a full correct frame.
- Integration with `dpsk_modulator` (carrier=1000), frame byte 0xA5:
  - modulator reset held while idle.
  - dpsk_out polarity changes exactly at symbol boundaries where serial_data toggles.
